ccm_in_packer: RTL

Upstream feeder for the CCM engine. Accepts the TX/RX payload as a stream of 32-bit words and packs it into 128-bit AES blocks. Presents each block to the CCM controller on `ccmInData`/`ccmInValid`, together with a per-byte valid mask (`maskReg`) and an end-of-payload pulse (`payloadEnd_p`). Sits between the MAC payload FIFO and the `ccm` top level, driven by its `loadMsg_p` request.

---
 rtl/ccm_in_packer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ccm_in_packer.sv
// Packs a 32-bit payload word stream into 128-bit AES blocks for the CCM engine,
// with a per-byte valid mask and an end-of-payload pulse.
module ccm_in_packer (
    input  logic         pClk,
    input  logic         nPRst,
    input  logic         nSRst,
    input  logic         initCCM_p,
    input  logic [15:0]  payloadLen,
    input  logic         rxError_p,
    input  logic         tcTxErrorP,
    input  logic [31:0]  wordIn,
    input  logic         wordInValid,
    output logic         wordInReady,
    input  logic         loadMsg_p,
    output logic [127:0] ccmInData,
    output logic         ccmInValid,
    output logic [127:0] maskReg,
    output logic         payloadEnd_p,
    output logic         packerIdle
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD, S_END} state_t;

    state_t        state, state_nxt;
    logic [15:0]   rem_bytes, rem_nxt, rem_dec;
    logic [1:0]    word_pos, pos_nxt;
    logic [127:0]  data_nxt, mask_nxt;
    logic          valid_nxt, end_nxt;
    logic [2:0]    take;
    logic [31:0]   slot_data, slot_mask;
    logic          abort;

    assign abort       = rxError_p | tcTxErrorP;
    assign wordInReady = (state == S_FILL);
    assign packerIdle  = (state == S_IDLE);

    // Bytes taken from this word: min(4, rem_bytes); lanes past that are zeroed.
    assign take    = (rem_bytes >= 16'd4) ? 3'd4 : rem_bytes[2:0];
    assign rem_dec = rem_bytes - {13'd0, take};

    assign slot_mask = {{8{take > 3'd0}}, {8{take > 3'd1}}, {8{take > 3'd2}}, {8{take > 3'd3}}};
    assign slot_data = {wordIn[7:0], wordIn[15:8], wordIn[23:16], wordIn[31:24]} & slot_mask;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem_bytes;
        pos_nxt   = word_pos;
        data_nxt  = ccmInData;
        mask_nxt  = maskReg;
        valid_nxt = ccmInValid;
        end_nxt   = 1'b0;

        if (abort) begin
            state_nxt = S_IDLE;
            rem_nxt   = '0;
            pos_nxt   = '0;
            data_nxt  = '0;
            mask_nxt  = '0;
            valid_nxt = 1'b0;
        end else if (initCCM_p) begin
            rem_nxt   = payloadLen;
            pos_nxt   = '0;
            data_nxt  = '0;
            mask_nxt  = '0;
            valid_nxt = 1'b0;
            if (payloadLen == 16'd0) begin
                state_nxt = S_END;
                end_nxt   = 1'b1;
            end else begin
                state_nxt = S_FILL;
            end
        end else begin
            case (state)
                S_FILL: begin
                    if (wordInValid) begin
                        // Unwritten slots are already zero, so OR-ing the shifted slot is enough.
                        data_nxt = ccmInData | ({slot_data, 96'd0} >> {word_pos, 5'd0});
                        mask_nxt = maskReg   | ({slot_mask, 96'd0} >> {word_pos, 5'd0});
                        rem_nxt  = rem_dec;
                        pos_nxt  = word_pos + 2'd1;
                        if (word_pos == 2'd3 || rem_dec == 16'd0) begin
                            state_nxt = S_HOLD;
                            valid_nxt = 1'b1;
                            end_nxt   = (rem_dec == 16'd0);
                        end
                    end
                end
                S_HOLD: begin
                    if (loadMsg_p) begin
                        data_nxt  = '0;
                        mask_nxt  = '0;
                        pos_nxt   = '0;
                        valid_nxt = 1'b0;
                        state_nxt = (rem_bytes != 16'd0) ? S_FILL : S_IDLE;
                    end
                end
                S_END:   state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge pClk or negedge nPRst) begin
        if (!nPRst) begin
            state        <= S_IDLE;
            rem_bytes    <= '0;
            word_pos     <= '0;
            ccmInData    <= '0;
            maskReg      <= '0;
            ccmInValid   <= 1'b0;
            payloadEnd_p <= 1'b0;
        end else if (!nSRst) begin
            state        <= S_IDLE;
            rem_bytes    <= '0;
            word_pos     <= '0;
            ccmInData    <= '0;
            maskReg      <= '0;
            ccmInValid   <= 1'b0;
            payloadEnd_p <= 1'b0;
        end else begin
            state        <= state_nxt;
            rem_bytes    <= rem_nxt;
            word_pos     <= pos_nxt;
            ccmInData    <= data_nxt;
            maskReg      <= mask_nxt;
            ccmInValid   <= valid_nxt;
            payloadEnd_p <= end_nxt;
        end
    end

endmodule
